// File: rtl/cnn_layer_accum_if.sv
// Stream bundle around one output-channel accumulator: conv partial sums in, pooled pixels out.
// The accumulator block takes the slave side; the conv engine / ofm writer side takes master.
interface cnn_layer_accum_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PSUM_WIDTH = 20
);
  logic                         psum_valid;
  logic                         psum_ready;
  logic signed [PSUM_WIDTH-1:0] psum_data;
  logic                         ofm_valid;
  logic                         ofm_ready;
  logic signed [DATA_WIDTH-1:0] ofm_data;
  logic                         ofm_last;

  modport master (
    output psum_valid, psum_data, ofm_ready,
    input  psum_ready, ofm_valid, ofm_data, ofm_last
  );

  modport slave (
    input  psum_valid, psum_data, ofm_ready,
    output psum_ready, ofm_valid, ofm_data, ofm_last
  );
endinterface

// File: rtl/cnn_layer_accum.sv
// Per-output-channel accumulate over input channels, 2x2/stride-2 max/avg pooling,
// bias, optional ReLU, arithmetic shift and saturation to DATA_WIDTH.
module cnn_layer_accum #(
  parameter int DATA_WIDTH = 8,
  parameter int PSUM_WIDTH = 20,
  parameter int ACC_WIDTH  = 26,
  parameter int MAP_SIZE   = 32,
  parameter int MAX_IN_CH  = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [$clog2(MAX_IN_CH+1)-1:0]     cfg_in_ch,
  input  logic                               cfg_pool_avg,
  input  logic                               cfg_relu_en,
  input  logic [3:0]                         cfg_shift,
  input  logic signed [2*DATA_WIDTH-1:0]     bias,
  cnn_layer_accum_if.slave                   strm,
  output logic                               busy,
  output logic                               done
);

  localparam int CH_W  = $clog2(MAX_IN_CH+1);
  localparam int NPIX  = MAP_SIZE * MAP_SIZE;
  localparam int PIX_W = $clog2(NPIX);
  localparam int HALF  = MAP_SIZE / 2;
  localparam int PR_W  = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int W2    = ACC_WIDTH + 2;
  localparam int BW    = 2 * DATA_WIDTH;

  localparam logic signed [W2-1:0] SAT_MAX = W2'((64'sd1 <<< (DATA_WIDTH-1)) - 64'sd1);
  localparam logic signed [W2-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    POOL,
    OUT,
    DONE
  } state_t;

  state_t                        state;
  logic [PIX_W-1:0]              pix_cnt;
  logic [CH_W-1:0]               ch_cnt;
  logic [CH_W-1:0]               in_ch_q;
  logic                          pool_avg_q;
  logic                          relu_q;
  logic [3:0]                    shift_q;
  logic signed [BW-1:0]          bias_q;
  logic [PR_W-1:0]               prow;
  logic [PR_W-1:0]               pcol;
  logic [1:0]                    step;
  logic signed [ACC_WIDTH-1:0]   best_q;
  logic signed [W2-1:0]          sum_q;

  logic signed [ACC_WIDTH-1:0]   acc_mem [NPIX];

  logic                          psum_fire;
  logic                          last_pix_of_map;
  logic                          last_ch;
  logic                          last_pool_pix;
  logic [PIX_W-1:0]              pool_addr;
  logic [PIX_W-1:0]              rd_addr;
  logic signed [ACC_WIDTH-1:0]   rd_val;
  logic signed [ACC_WIDTH-1:0]   psum_ext;
  logic signed [W2-1:0]          rd_ext;
  logic signed [ACC_WIDTH-1:0]   max_val;
  logic signed [W2-1:0]          max_ext;
  logic signed [W2-1:0]          sum_all;
  logic signed [W2-1:0]          pooled;
  logic signed [W2-1:0]          v_bias;
  logic signed [W2-1:0]          v_relu;
  logic signed [W2-1:0]          v_shift;
  logic signed [DATA_WIDTH-1:0]  sat_val;

  assign psum_fire       = (state == ACCUM) && strm.psum_valid && strm.psum_ready;
  assign last_pix_of_map = (pix_cnt == PIX_W'(NPIX-1));
  assign last_ch         = (ch_cnt == in_ch_q - CH_W'(1));
  assign last_pool_pix   = (prow == PR_W'(HALF-1)) && (pcol == PR_W'(HALF-1));

  // Window walk order: top-left, top-right, bottom-left, bottom-right
  assign pool_addr = PIX_W'({prow, step[1]}) * PIX_W'(MAP_SIZE) + PIX_W'({pcol, step[0]});
  assign rd_addr   = (state == ACCUM) ? pix_cnt : pool_addr;
  assign rd_val    = acc_mem[rd_addr];

  assign psum_ext = {{(ACC_WIDTH-PSUM_WIDTH){strm.psum_data[PSUM_WIDTH-1]}}, strm.psum_data};
  assign rd_ext   = {{2{rd_val[ACC_WIDTH-1]}}, rd_val};
  assign max_val  = (rd_val > best_q) ? rd_val : best_q;
  assign max_ext  = {{2{max_val[ACC_WIDTH-1]}}, max_val};
  assign sum_all  = sum_q + rd_ext;
  assign pooled   = pool_avg_q ? (sum_all >>> 2) : max_ext;
  assign v_bias   = pooled + {{(W2-BW){bias_q[BW-1]}}, bias_q};
  assign v_relu   = (relu_q && v_bias[W2-1]) ? '0 : v_bias;
  assign v_shift  = v_relu >>> shift_q;

  always_comb begin
    sat_val = v_shift[DATA_WIDTH-1:0];
    if (v_shift > SAT_MAX) begin
      sat_val = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (v_shift < SAT_MIN) begin
      sat_val = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end
  end

  // Channel 0 overwrites, so the RAM never needs clearing between runs or after reset
  always_ff @(posedge clk) begin
    if (psum_fire) begin
      acc_mem[pix_cnt] <= (ch_cnt == '0) ? psum_ext : rd_val + psum_ext;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      pix_cnt         <= '0;
      ch_cnt          <= '0;
      in_ch_q         <= CH_W'(1);
      pool_avg_q      <= 1'b0;
      relu_q          <= 1'b0;
      shift_q         <= '0;
      bias_q          <= '0;
      prow            <= '0;
      pcol            <= '0;
      step            <= '0;
      best_q          <= '0;
      sum_q           <= '0;
      strm.psum_ready <= 1'b0;
      strm.ofm_valid  <= 1'b0;
      strm.ofm_data   <= '0;
      strm.ofm_last   <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            in_ch_q         <= (cfg_in_ch == '0) ? CH_W'(1) : cfg_in_ch;
            pool_avg_q      <= cfg_pool_avg;
            relu_q          <= cfg_relu_en;
            shift_q         <= cfg_shift;
            bias_q          <= bias;
            pix_cnt         <= '0;
            ch_cnt          <= '0;
            strm.psum_ready <= 1'b1;
            busy            <= 1'b1;
            state           <= ACCUM;
          end
        end
        ACCUM: begin
          if (psum_fire) begin
            if (last_pix_of_map) begin
              pix_cnt <= '0;
              if (last_ch) begin
                ch_cnt          <= '0;
                strm.psum_ready <= 1'b0;
                prow            <= '0;
                pcol            <= '0;
                step            <= '0;
                state           <= POOL;
              end else begin
                ch_cnt <= ch_cnt + CH_W'(1);
              end
            end else begin
              pix_cnt <= pix_cnt + PIX_W'(1);
            end
          end
        end
        POOL: begin
          step   <= step + 2'd1;
          best_q <= (step == 2'd0) ? rd_val : max_val;
          sum_q  <= (step == 2'd0) ? rd_ext : sum_all;
          if (step == 2'd3) begin
            strm.ofm_data  <= sat_val;
            strm.ofm_valid <= 1'b1;
            strm.ofm_last  <= last_pool_pix;
            state          <= OUT;
          end
        end
        OUT: begin
          if (strm.ofm_ready) begin
            strm.ofm_valid <= 1'b0;
            strm.ofm_last  <= 1'b0;
            if (last_pool_pix) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              step  <= '0;
              state <= POOL;
              if (pcol == PR_W'(HALF-1)) begin
                pcol <= '0;
                prow <= prow + PR_W'(1);
              end else begin
                pcol <= pcol + PR_W'(1);
              end
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_layer_accum.sv
// Bench for cnn_layer_accum on a 4x4 map: directed corner cases plus randomized runs
// checked against an arithmetic model of accumulate/pool/bias/relu/shift/saturate.
module tb_cnn_layer_accum;

  localparam int DW   = 8;
  localparam int PW   = 20;
  localparam int AW   = 26;
  localparam int MS   = 4;
  localparam int MIC  = 16;
  localparam int NPIX = MS * MS;
  localparam int CHW  = $clog2(MIC+1);

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [CHW-1:0]    cfg_in_ch;
  logic              cfg_pool_avg;
  logic              cfg_relu_en;
  logic [3:0]        cfg_shift;
  logic signed [15:0] bias;
  logic              busy;
  logic              done;

  cnn_layer_accum_if #(.DATA_WIDTH(DW), .PSUM_WIDTH(PW)) bus ();

  cnn_layer_accum #(
    .DATA_WIDTH(DW), .PSUM_WIDTH(PW), .ACC_WIDTH(AW), .MAP_SIZE(MS), .MAX_IN_CH(MIC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_in_ch(cfg_in_ch),
    .cfg_pool_avg(cfg_pool_avg), .cfg_relu_en(cfg_relu_en), .cfg_shift(cfg_shift),
    .bias(bias), .strm(bus.slave), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit stuck  = 1'b0;
  int psums [MIC*NPIX];

  int r_in, r_shift, r_bias, r_stall;
  bit r_avg, r_relu;

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Reference: sum channels with accumulator wrap, then pool/bias/relu/shift/clamp
  function automatic longint model_pixel(input int in_ch, input bit avg, input bit relu,
                                         input int shift, input longint bias_v, input int k);
    longint acc [4];
    longint pooled, v, t;
    int pr, pc, pix;
    pr = k / 2;
    pc = k % 2;
    for (int w = 0; w < 4; w++) begin
      pix = (2*pr + w/2) * MS + 2*pc + (w % 2);
      t = 0;
      for (int ch = 0; ch < in_ch; ch++) t += psums[ch*NPIX + pix];
      t = t & ((64'sd1 <<< AW) - 1);
      if (t >= (64'sd1 <<< (AW-1))) t -= (64'sd1 <<< AW);
      acc[w] = t;
    end
    if (avg) begin
      pooled = (acc[0] + acc[1] + acc[2] + acc[3]) >>> 2;
    end else begin
      pooled = acc[0];
      for (int w = 1; w < 4; w++) if (acc[w] > pooled) pooled = acc[w];
    end
    v = pooled + bias_v;
    if (relu && v < 0) v = 0;
    v = v >>> shift;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return v;
  endfunction

  task automatic fill_all(input int val);
    for (int i = 0; i < MIC*NPIX; i++) psums[i] = val;
  endtask

  task automatic feed_beat(input int d);
    int n;
    if (stuck) return;
    bus.psum_valid = 1'b1;
    bus.psum_data  = PW'(d);
    n = 0;
    while (!bus.psum_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.psum_ready) begin
      checkOutput("psum_ready_timeout", bus.psum_ready, 1);
      stuck = 1'b1;
    end
    @(posedge clk); #1;
    bus.psum_valid = 1'b0;
  endtask

  task automatic applyStimulus(input string name, input int in_ch, input bit avg, input bit relu,
                               input int shift, input int bias_v, input int stall_pix,
                               input bit gaps, input bit use_fixed, input longint fixed_exp);
    int eff_ch, lat, unstable;
    longint expv, d0, l0;
    eff_ch = (in_ch == 0) ? 1 : in_ch;
    stuck  = 1'b0;
    cfg_in_ch    = CHW'(in_ch);
    cfg_pool_avg = avg;
    cfg_relu_en  = relu;
    cfg_shift    = 4'(shift);
    bias         = 16'(bias_v);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput({name, ".busy_after_start"}, busy, 1);
    // Scramble the config: the running job must keep its latched copy
    cfg_in_ch    = CHW'($urandom_range(0, MIC));
    cfg_pool_avg = ~avg;
    cfg_relu_en  = ~relu;
    cfg_shift    = 4'($urandom_range(0, 15));
    for (int ch = 0; ch < eff_ch; ch++) begin
      for (int p = 0; p < NPIX; p++) begin
        if (gaps && $urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
        end
        feed_beat(psums[ch*NPIX + p]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      bus.ofm_ready = (k != stall_pix);
      lat = 0;
      while (!bus.ofm_valid && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      checkOutput({name, ".latency"}, lat, 4);
      expv = model_pixel(eff_ch, avg, relu, shift, bias_v, k);
      checkOutput({name, ".data"}, bus.ofm_data, expv);
      if (use_fixed) checkOutput({name, ".data_fixed"}, bus.ofm_data, fixed_exp);
      checkOutput({name, ".last"}, bus.ofm_last, (k == 3) ? 1 : 0);
      if (k == stall_pix) begin
        d0 = bus.ofm_data;
        l0 = bus.ofm_last;
        unstable = 0;
        for (int c = 0; c < 10; c++) begin
          start        = (c == 4);
          cfg_in_ch    = CHW'(1);
          cfg_pool_avg = ~avg;
          @(posedge clk); #1;
          if (bus.ofm_data !== DW'(d0) || bus.ofm_last !== l0[0] || !bus.ofm_valid
              || bus.psum_ready || !busy) unstable++;
        end
        start = 1'b0;
        checkOutput({name, ".stall_stable"}, unstable, 0);
        bus.ofm_ready = 1'b1;
      end
      @(posedge clk); #1;
      checkOutput({name, ".valid_drop"}, bus.ofm_valid, 0);
    end
    checkOutput({name, ".done_pulse"}, done, 1);
    @(posedge clk); #1;
    checkOutput({name, ".done_fall"}, done, 0);
    checkOutput({name, ".busy_fall"}, busy, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    cfg_in_ch = '0;
    cfg_pool_avg = 1'b0;
    cfg_relu_en = 1'b0;
    cfg_shift = '0;
    bias = '0;
    bus.psum_valid = 1'b0;
    bus.psum_data = '0;
    bus.ofm_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset.psum_ready", bus.psum_ready, 0);
    checkOutput("reset.ofm_valid", bus.ofm_valid, 0);
    checkOutput("reset.ofm_data", bus.ofm_data, 0);
    checkOutput("reset.ofm_last", bus.ofm_last, 0);
    checkOutput("reset.busy", busy, 0);
    checkOutput("reset.done", done, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] single channel max pooling");
    fill_all(8);
    applyStimulus("t1", 1, 0, 0, 0, 0, -1, 0, 1, 8);

    $display("[TB] three channels, avg pooling, negative bias");
    fill_all(100);
    applyStimulus("t2", 3, 1, 0, 2, -20, -1, 1, 1, 70);

    $display("[TB] mixed-sign window");
    fill_all(0);
    for (int p = 0; p < NPIX; p++) begin
      case ({(p / MS) % 2 == 1, (p % MS) % 2 == 1})
        2'b00:   psums[p] = 1;
        2'b01:   psums[p] = 2;
        2'b10:   psums[p] = 3;
        default: psums[p] = -10;
      endcase
    end
    applyStimulus("t3max", 1, 0, 0, 0, 0, -1, 0, 1, 3);
    applyStimulus("t3avg", 1, 1, 0, 0, 0, -1, 0, 1, -1);
    applyStimulus("t3relu", 1, 1, 1, 0, 0, -1, 0, 1, 0);

    $display("[TB] saturation");
    fill_all(1000);
    applyStimulus("t4pos", 1, 0, 0, 0, 0, -1, 0, 1, 127);
    fill_all(-1000);
    applyStimulus("t4neg", 1, 0, 0, 0, 0, -1, 0, 1, -128);
    applyStimulus("t4negrelu", 1, 0, 1, 0, 0, -1, 0, 1, 0);

    $display("[TB] output backpressure with ignored start");
    fill_all(8);
    applyStimulus("t5", 1, 0, 0, 0, 0, 1, 0, 1, 8);

    $display("[TB] reset during accumulation");
    fill_all(8);
    cfg_in_ch = CHW'(2);
    cfg_pool_avg = 1'b0;
    cfg_relu_en = 1'b0;
    cfg_shift = '0;
    bias = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    stuck = 1'b0;
    for (int i = 0; i < NPIX + 5; i++) feed_beat(99);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("t6.psum_ready", bus.psum_ready, 0);
    checkOutput("t6.busy", busy, 0);
    checkOutput("t6.ofm_valid", bus.ofm_valid, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus("t6rerun", 1, 0, 0, 0, 0, -1, 0, 1, 8);

    $display("[TB] zero channel count treated as one");
    for (int i = 0; i < MIC*NPIX; i++) psums[i] = $urandom_range(0, 400) - 200;
    applyStimulus("t7zero", 0, 1, 0, 1, 5, -1, 0, 0, 0);

    $display("[TB] randomized runs");
    for (int run = 0; run < 6; run++) begin
      for (int i = 0; i < MIC*NPIX; i++) psums[i] = int'($urandom_range(0, (1 << PW) - 1)) - (1 << (PW-1));
      r_in    = $urandom_range(1, MIC);
      r_avg   = 1'($urandom_range(0, 1));
      r_relu  = 1'($urandom_range(0, 1));
      r_shift = $urandom_range(0, 15);
      r_bias  = $urandom_range(0, 65535) - 32768;
      r_stall = $urandom_range(0, 5);
      applyStimulus("rand", r_in, r_avg, r_relu, r_shift, r_bias, r_stall, 1, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
